// File: rtl/freq_meter_counter_pkg.sv
// Shared definitions for the frequency-meter gate path: state encodings and
// default counter geometry used by the gate generator, counter and display stages.
package freq_meter_counter_pkg;

    localparam int DEF_CNT_W      = 32;
    localparam int DEF_GATE_SHIFT = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/freq_meter_counter_edge_sync.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector; o_rise is a single-clock pulse per synchronised low-to-high transition.
module freq_meter_counter_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_meter_counter.sv
// Counts synchronised rising edges of sig_in while gate_en is high and latches the
// raw count, the count scaled to Hz and a saturation flag when the window closes.
module freq_meter_counter
    import freq_meter_counter_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GATE_SHIFT = DEF_GATE_SHIFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate_en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] cnt_raw,
    output logic [CNT_W-1:0] freq_out,
    output logic             overflow,
    output logic             freq_valid,
    output logic             busy
);

    logic             w_sig_rise;
    logic             w_gate_rise;
    logic             w_gate_fall;
    logic             w_load;
    logic             r_gate_d;
    logic             r_armed;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_ovf;
    logic             w_ovf_next;
    logic [CNT_W-1:0] r_cnt_raw;
    logic [CNT_W-1:0] r_freq_out;
    logic             r_overflow;
    logic             r_freq_valid;

    freq_meter_counter_edge_sync u_sig_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sig_in),
        .o_rise  (w_sig_rise)
    );

    // r_armed stays low until gate_en has been seen low once after reset, so a
    // window already open at reset release never looks like a fresh gate_rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_d <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_gate_d <= gate_en;
            if (!gate_en) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_gate_rise = gate_en & ~r_gate_d & r_armed;
    assign w_gate_fall = ~gate_en & r_gate_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
        end
    end

    // An edge in the closing cycle is dropped because gate_fall takes priority.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gate_rise) begin
                    w_cnt_next   = {{(CNT_W-1){1'b0}}, w_sig_rise};
                    w_ovf_next   = 1'b0;
                    w_state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_gate_fall) begin
                    w_load       = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_sig_rise) begin
                    if (&r_cnt) begin
                        w_ovf_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_raw    <= '0;
            r_freq_out   <= '0;
            r_overflow   <= 1'b0;
            r_freq_valid <= 1'b0;
        end else begin
            r_freq_valid <= w_load;
            if (w_load) begin
                r_cnt_raw  <= r_cnt;
                r_freq_out <= r_cnt >> GATE_SHIFT;
                r_overflow <= r_ovf;
            end
        end
    end

    assign cnt_raw    = r_cnt_raw;
    assign freq_out   = r_freq_out;
    assign overflow   = r_overflow;
    assign freq_valid = r_freq_valid;
    assign busy       = (r_state == ST_COUNT);

endmodule

// File: tb/tb_freq_meter_counter.sv
// Directed bench for freq_meter_counter: a 32-bit and an 8-bit instance share
// stimulus so saturation can be observed alongside the unsaturated count.
module tb_freq_meter_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        gate_en = 1'b0;
    logic        sig_in = 1'b0;
    logic [31:0] cntRaw;
    logic [31:0] freqOut;
    logic        overflow;
    logic        freqValid;
    logic        busy;
    logic [7:0]  cntRaw8;
    logic [7:0]  freqOut8;
    logic        overflow8;
    logic        freqValid8;
    logic        busy8;
    int          checks = 0;
    int          failures = 0;
    int          validCount = 0;
    int          validBefore;

    always #5 clk = ~clk;

    freq_meter_counter #(.CNT_W(32), .GATE_SHIFT(1)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .gate_en    (gate_en),
        .sig_in     (sig_in),
        .cnt_raw    (cntRaw),
        .freq_out   (freqOut),
        .overflow   (overflow),
        .freq_valid (freqValid),
        .busy       (busy)
    );

    freq_meter_counter #(.CNT_W(8), .GATE_SHIFT(1)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .gate_en    (gate_en),
        .sig_in     (sig_in),
        .cnt_raw    (cntRaw8),
        .freq_out   (freqOut8),
        .overflow   (overflow8),
        .freq_valid (freqValid8),
        .busy       (busy8)
    );

    // Counts every cycle in which the 32-bit instance presents a result.
    always @(negedge clk) begin
        if (freqValid) validCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs at the falling edge and returns just after the
    // rising edge that sampled them.
    task automatic applyStimulus(input logic g, input logic s);
        @(negedge clk);
        gate_en = g;
        sig_in  = s;
        @(posedge clk);
        #1;
    endtask

    // period==0 holds sig_in at (hi!=0); otherwise sig_in is high for the first
    // hi cycles of each period, starting at the first cycle of the window.
    task automatic runWindow(input int n, input int period, input int hi);
        for (int i = 0; i < n; i++) begin
            if (period == 0) applyStimulus(1'b1, hi != 0);
            else             applyStimulus(1'b1, (i % period) < hi);
        end
    endtask

    task automatic closeWindow(input string tag,
                               input logic [31:0] expCnt, input logic [31:0] expFreq, input logic expOvf,
                               input logic [31:0] expCnt8, input logic [31:0] expFreq8, input logic expOvf8);
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, "_valid"}, {31'd0, freqValid}, 32'd1);
        checkOutput({tag, "_cnt"}, cntRaw, expCnt);
        checkOutput({tag, "_freq"}, freqOut, expFreq);
        checkOutput({tag, "_ovf"}, {31'd0, overflow}, {31'd0, expOvf});
        checkOutput({tag, "_valid8"}, {31'd0, freqValid8}, 32'd1);
        checkOutput({tag, "_cnt8"}, {24'd0, cntRaw8}, expCnt8);
        checkOutput({tag, "_freq8"}, {24'd0, freqOut8}, expFreq8);
        checkOutput({tag, "_ovf8"}, {31'd0, overflow8}, {31'd0, expOvf8});
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, "_valid_drop"}, {31'd0, freqValid}, 32'd0);
        checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #12;
        checkOutput("rst_cnt", cntRaw, 32'd0);
        checkOutput("rst_freq", freqOut, 32'd0);
        checkOutput("rst_valid", {31'd0, freqValid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0);

        $display("[TB] window 1000 clk, period 10");
        runWindow(1000, 10, 5);
        checkOutput("t2_busy", {31'd0, busy}, 32'd1);
        checkOutput("t2_early_valid", {31'd0, freqValid}, 32'd0);
        closeWindow("t2", 32'd100, 32'd50, 1'b0, 32'd100, 32'd50, 1'b0);

        $display("[TB] async reset mid-window");
        runWindow(50, 4, 2);
        checkOutput("t1_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t1_cnt", cntRaw, 32'd0);
        checkOutput("t1_freq", freqOut, 32'd0);
        checkOutput("t1_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("t1_valid", {31'd0, freqValid}, 32'd0);
        checkOutput("t1_busy", {31'd0, busy}, 32'd0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        validBefore = validCount;

        $display("[TB] gate high at reset release");
        runWindow(500, 4, 2);
        checkOutput("t3_partial_busy", {31'd0, busy}, 32'd0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("t3_no_valid", validCount, validBefore);
        checkOutput("t3_no_result", cntRaw, 32'd0);
        runWindow(200, 4, 2);
        closeWindow("t3", 32'd50, 32'd25, 1'b0, 32'd50, 32'd25, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0);
        checkOutput("t3_hold", cntRaw, 32'd50);

        $display("[TB] saturation");
        runWindow(601, 2, 1);
        closeWindow("t4_sat", 32'd300, 32'd150, 1'b0, 32'd255, 32'd127, 1'b1);
        runWindow(40, 4, 2);
        closeWindow("t4_next", 32'd10, 32'd5, 1'b0, 32'd10, 32'd5, 1'b0);

        $display("[TB] constant-high input");
        repeat (3) applyStimulus(1'b0, 1'b1);
        runWindow(20, 0, 1);
        closeWindow("t5", 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);

        $display("[TB] edges coincident with gate edges");
        repeat (3) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, (i < 2) || (i >= 8));
        end
        closeWindow("t6", 32'd1, 32'd0, 1'b0, 32'd1, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
